// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one fixed-latency data memory between the CPU load/store path and a
// debug/loader requester. A four-state sequencer (IDLE, ISSUE, WAIT, RESP)
// runs one transaction at a time. Round-robin arbitration means neither port
// can starve the other. Each port gets a one-cycle ack pulse on completion.
//
// Parameters
//   AW       address width
//   DW       data width
//   MEM_LAT  memory read latency in cycles from the issue edge (1..15 only)
//
// Ports
//   Clock, Reset                   system clock, async active-low reset
//   cpu_req/we/addr/wdata          CPU request; req held until cpu_ack
//   cpu_rdata, cpu_ack, cpu_stall  CPU response and stall indication
//   dbg_req/we/addr/wdata          debug/loader request; req held until dbg_ack
//   dbg_rdata, dbg_ack             debug/loader response
//   mem_en/we/addr/wdata           memory command, driven only in ISSUE
//   mem_rdata                      memory read data, valid MEM_LAT cycles
//                                  after the issue edge
//   busy                           sequencer not idle
//   grant_id                       owning port (0 = CPU, 1 = debug)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          Clock,
  input  logic          Reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy,
  output logic          grant_id
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // The counter is 4 bits wide, so only latencies of 1..15 can be represented.
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

  logic          any_req;
  logic          idle_winner;
  logic          other_port;
  logic          other_req;
  logic          granted_we;
  logic [AW-1:0] granted_addr;
  logic [DW-1:0] granted_wdata;

  // On a tie, the port that did not win last time is chosen.
  // last resets to the debug port, so the CPU wins the first tie.
  assign any_req     = cpu_req | dbg_req;
  assign idle_winner = (cpu_req & dbg_req) ? ~last_q : dbg_req;

  // In RESP only the port that is not being acked may be picked.
  // This forces a port that re-requests to go back through IDLE.
  assign other_port = ~grant_q;
  assign other_req  = grant_q ? cpu_req : dbg_req;

  // Commands come from the granted port's live inputs. The requester keeps
  // them stable through ISSUE, so no request-side staging is needed.
  assign granted_we    = grant_q ? dbg_we    : cpu_we;
  assign granted_addr  = grant_q ? dbg_addr  : cpu_addr;
  assign granted_wdata = grant_q ? dbg_wdata : cpu_wdata;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = idle_winner;
          last_d  = idle_winner;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Record read/write now, because requester inputs may change once
        // ISSUE is over.
        cnt_d   = LAT_INIT;
        we_d    = granted_we;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // A count of 1 marks the cycle in which mem_rdata is valid.
        if (cnt_q == 4'd1) begin
          if (!we_q) begin
            if (grant_q == PORT_DBG) dbg_rdata_d = mem_rdata;
            else                     cpu_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        if (other_req) begin
          grant_d = other_port;
          last_d  = other_port;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Reset drops any transaction in flight; it is never acked.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= PORT_CPU;
      last_q      <= PORT_DBG;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Memory bus is held at zero outside ISSUE so idle cycles are easy to spot.
  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = mem_en & granted_we;
  assign mem_addr  = mem_en ? granted_addr  : '0;
  assign mem_wdata = mem_en ? granted_wdata : '0;

  assign cpu_ack   = (state_q == ST_RESP) & (grant_q == PORT_CPU);
  assign dbg_ack   = (state_q == ST_RESP) & (grant_q == PORT_DBG);
  assign cpu_stall = cpu_req & ~cpu_ack;

  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives two dmem_arbiter instances: index 0 uses MEM_LAT=1 and index 1 uses
// MEM_LAT=4. Each instance has its own latency-accurate memory model.
// Requests push hand-computed responses (rdata and ack cycle) into one queue
// per instance and port. A monitor pops and compares on every ack.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  typedef struct {
    logic [31:0] rdata;
    int          cycle;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetN [2];
  int          cyc = 0;

  logic        cpuReq [2];
  logic        cpuWe [2];
  logic [31:0] cpuAddr [2];
  logic [31:0] cpuWdata [2];
  logic [31:0] cpuRdata [2];
  logic        cpuAck [2];
  logic        cpuStall [2];
  logic        dbgReq [2];
  logic        dbgWe [2];
  logic [31:0] dbgAddr [2];
  logic [31:0] dbgWdata [2];
  logic [31:0] dbgRdata [2];
  logic        dbgAck [2];
  logic        memEn [2];
  logic        memWe [2];
  logic [31:0] memAddr [2];
  logic [31:0] memWdata [2];
  logic [31:0] memRdata [2];
  logic        busy [2];
  logic        grantId [2];

  logic [31:0] mem [2][256];
  logic [31:0] pipe [2][4];
  logic        preEn = 1'b0;
  int          preInst = 0;
  logic [7:0]  preAddr = 8'd0;
  logic [31:0] preData = 32'd0;

  exp_t        expQ [4][$];
  int          checks = 0;
  int          errors = 0;
  int          memEnCount [2];
  int          memEnCycle [2];
  int          memWeCount [2];
  int          startCycle = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut0 (
    .Clock(clock), .Reset(resetN[0]),
    .cpu_req(cpuReq[0]), .cpu_we(cpuWe[0]), .cpu_addr(cpuAddr[0]),
    .cpu_wdata(cpuWdata[0]), .cpu_rdata(cpuRdata[0]), .cpu_ack(cpuAck[0]),
    .cpu_stall(cpuStall[0]),
    .dbg_req(dbgReq[0]), .dbg_we(dbgWe[0]), .dbg_addr(dbgAddr[0]),
    .dbg_wdata(dbgWdata[0]), .dbg_rdata(dbgRdata[0]), .dbg_ack(dbgAck[0]),
    .mem_en(memEn[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]),
    .mem_wdata(memWdata[0]), .mem_rdata(memRdata[0]),
    .busy(busy[0]), .grant_id(grantId[0])
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) dut1 (
    .Clock(clock), .Reset(resetN[1]),
    .cpu_req(cpuReq[1]), .cpu_we(cpuWe[1]), .cpu_addr(cpuAddr[1]),
    .cpu_wdata(cpuWdata[1]), .cpu_rdata(cpuRdata[1]), .cpu_ack(cpuAck[1]),
    .cpu_stall(cpuStall[1]),
    .dbg_req(dbgReq[1]), .dbg_we(dbgWe[1]), .dbg_addr(dbgAddr[1]),
    .dbg_wdata(dbgWdata[1]), .dbg_rdata(dbgRdata[1]), .dbg_ack(dbgAck[1]),
    .mem_en(memEn[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]),
    .mem_wdata(memWdata[1]), .mem_rdata(memRdata[1]),
    .busy(busy[1]), .grant_id(grantId[1])
  );

  // Memory model. The read is sampled on the issue edge and then travels
  // down a shift register. Stage 0 is visible MEM_LAT=1 cycles after issue,
  // and stage 3 is visible MEM_LAT=4 cycles after issue. Idle cycles shift
  // in zeros, so data captured in the wrong cycle shows up as a wrong value.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (preEn && preInst == i)
        mem[i][preAddr] <= preData;
      else if (memEn[i] && memWe[i])
        mem[i][memAddr[i][7:0]] <= memWdata[i];
      pipe[i][0] <= (memEn[i] && !memWe[i]) ? mem[i][memAddr[i][7:0]] : 32'd0;
      for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
    end
  end
  assign memRdata[0] = pipe[0][0];
  assign memRdata[1] = pipe[1][3];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic popAndCheck(input int inst, input int port,
                             input logic [31:0] rdata);
    exp_t  e;
    string tag;
    int    q;
    q = inst * 2 + port;
    tag = $sformatf("inst%0d %s", inst, (port == 0) ? "cpu" : "dbg");
    if (expQ[q].size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s unexpected ack: got ack expected none (cycle %0d)",
               tag, cyc);
    end else begin
      e = expQ[q].pop_front();
      checkOutput({tag, " ack cycle"}, 32'(cyc), 32'(e.cycle));
      checkOutput({tag, " rdata"}, rdata, e.rdata);
    end
  endtask

  // Scoreboard monitor and memory-bus observer.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (cpuAck[i]) popAndCheck(i, 0, cpuRdata[i]);
      if (dbgAck[i]) popAndCheck(i, 1, dbgRdata[i]);
      if (memEn[i]) begin
        memEnCount[i]++;
        memEnCycle[i] = cyc;
        if (memWe[i]) memWeCount[i]++;
      end else if (resetN[i]) begin
        checkOutput($sformatf("inst%0d idle mem bus", i),
                    memAddr[i] | memWdata[i] | 32'(memWe[i]), 32'd0);
      end
    end
  end

  task automatic preload(input int inst, input logic [7:0] addr,
                         input logic [31:0] data);
    @(negedge clock);
    preInst = inst;
    preAddr = addr;
    preData = data;
    preEn   = 1'b1;
    @(negedge clock);
    preEn   = 1'b0;
  endtask

  // Raises a request on the next falling edge and logs the expected response
  // at (start cycle + ackOffset). It then holds the request until ack and
  // drops it in the ack cycle.
  task automatic applyStimulus(input int inst, input int port, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input int ackOffset);
    exp_t e;
    bit   seen;
    @(negedge clock);
    e.rdata = expRdata;
    e.cycle = cyc + ackOffset;
    expQ[inst * 2 + port].push_back(e);
    if (port == 0) begin
      cpuWe[inst] = we; cpuAddr[inst] = addr; cpuWdata[inst] = wdata;
      cpuReq[inst] = 1'b1;
    end else begin
      dbgWe[inst] = we; dbgAddr[inst] = addr; dbgWdata[inst] = wdata;
      dbgReq[inst] = 1'b1;
    end
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clock);
      seen = (port == 0) ? cpuAck[inst] : dbgAck[inst];
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL inst%0d port%0d ack timeout: got none expected ack",
               inst, port);
    end
    if (port == 0) begin
      cpuReq[inst] = 1'b0; cpuWe[inst] = 1'b0;
      cpuAddr[inst] = 32'd0; cpuWdata[inst] = 32'd0;
    end else begin
      dbgReq[inst] = 1'b0; dbgWe[inst] = 1'b0;
      dbgAddr[inst] = 32'd0; dbgWdata[inst] = 32'd0;
    end
  endtask

  task automatic checkReset(input int inst);
    string t;
    t = $sformatf("inst%0d reset ", inst);
    checkOutput({t, "busy"},      32'(busy[inst]),    32'd0);
    checkOutput({t, "mem_en"},    32'(memEn[inst]),   32'd0);
    checkOutput({t, "mem_we"},    32'(memWe[inst]),   32'd0);
    checkOutput({t, "cpu_ack"},   32'(cpuAck[inst]),  32'd0);
    checkOutput({t, "dbg_ack"},   32'(dbgAck[inst]),  32'd0);
    checkOutput({t, "grant_id"},  32'(grantId[inst]), 32'd0);
    checkOutput({t, "cpu_rdata"}, cpuRdata[inst],     32'd0);
    checkOutput({t, "dbg_rdata"}, dbgRdata[inst],     32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int enBefore, weBefore;
    for (int i = 0; i < 2; i++) begin
      resetN[i] = 1'b0;
      cpuReq[i] = 1'b0; cpuWe[i] = 1'b0; cpuAddr[i] = 32'd0; cpuWdata[i] = 32'd0;
      dbgReq[i] = 1'b0; dbgWe[i] = 1'b0; dbgAddr[i] = 32'd0; dbgWdata[i] = 32'd0;
      memEnCount[i] = 0; memEnCycle[i] = 0; memWeCount[i] = 0;
    end
    #1;
    checkReset(0);
    checkReset(1);
    preload(0, 8'h10, 32'hDEADBEEF);
    preload(1, 8'h30, 32'hCAFEF00D);
    preload(1, 8'h50, 32'h0BADCAFE);
    @(negedge clock);
    resetN[0] = 1'b1;
    resetN[1] = 1'b1;
    repeat (2) @(negedge clock);

    // Single CPU read: mem_en only in cycle 1, stall over cycles 0..2, ack in 3.
    enBefore = memEnCount[0];
    fork
      applyStimulus(0, 0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 3);
      begin
        @(negedge clock);
        startCycle = cyc;
        for (int k = 0; k < 4; k++) begin
          #1;
          checkOutput($sformatf("t1 cpu_stall k%0d", k), 32'(cpuStall[0]),
                      (k <= 2) ? 32'd1 : 32'd0);
          @(negedge clock);
        end
      end
    join
    checkOutput("t1 mem_en count", 32'(memEnCount[0] - enBefore), 32'd1);
    checkOutput("t1 mem_en cycle", 32'(memEnCycle[0]), 32'(startCycle + 1));

    // Debug write, then CPU read-back of the same word.
    weBefore = memWeCount[0];
    enBefore = memEnCount[0];
    applyStimulus(0, 1, 1'b1, 32'h20, 32'h12345678, 32'd0, 3);
    checkOutput("t2 mem_we count", 32'(memWeCount[0] - weBefore), 32'd1);
    applyStimulus(0, 0, 1'b0, 32'h20, 32'd0, 32'h12345678, 3);
    checkOutput("t2 read mem_we count", 32'(memWeCount[0] - weBefore), 32'd1);
    checkOutput("t2 mem_en count", 32'(memEnCount[0] - enBefore), 32'd2);
    checkOutput("t2 dbg_rdata held", dbgRdata[0], 32'd0);

    // Reset returns the tie-break to the CPU and clears rdata.
    @(negedge clock);
    resetN[0] = 1'b0;
    #1;
    checkReset(0);
    @(negedge clock);
    resetN[0] = 1'b1;
    @(negedge clock);

    // Contention after reset: the CPU wins, then grants alternate with no gap.
    fork
      begin
        applyStimulus(0, 0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 3);
        applyStimulus(0, 0, 1'b0, 32'h20, 32'd0, 32'h12345678, 5);
        applyStimulus(0, 0, 1'b1, 32'h40, 32'hA5A5A5A5, 32'h12345678, 5);
      end
      begin
        applyStimulus(0, 1, 1'b0, 32'h20, 32'd0, 32'h12345678, 6);
        applyStimulus(0, 1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 5);
        applyStimulus(0, 1, 1'b0, 32'h40, 32'd0, 32'hA5A5A5A5, 5);
      end
    join

    // Request dropped in cycle 2 still completes, with only one mem_en.
    enBefore = memEnCount[0];
    @(negedge clock);
    expQ[0].push_back('{rdata: 32'h12345678, cycle: cyc + 3});
    cpuAddr[0] = 32'h20;
    cpuWe[0]   = 1'b0;
    cpuReq[0]  = 1'b1;
    repeat (2) @(negedge clock);
    cpuReq[0]  = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("t6 mem_en count", 32'(memEnCount[0] - enBefore), 32'd1);

    // MEM_LAT=4 debug read: busy over cycles 1..6, data valid in 5, ack in 6.
    fork
      applyStimulus(1, 1, 1'b0, 32'h30, 32'd0, 32'hCAFEF00D, 6);
      begin
        @(negedge clock);
        for (int k = 0; k < 8; k++) begin
          #1;
          checkOutput($sformatf("t4 busy k%0d", k), 32'(busy[1]),
                      (k >= 1 && k <= 6) ? 32'd1 : 32'd0);
          if (k == 5) checkOutput("t4 mem_rdata c5", memRdata[1], 32'hCAFEF00D);
          @(negedge clock);
        end
      end
    join

    // Reset during WAIT aborts the transaction without an ack.
    @(negedge clock);
    cpuAddr[1] = 32'h30;
    cpuWe[1]   = 1'b0;
    cpuReq[1]  = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("t5 busy in wait", 32'(busy[1]), 32'd1);
    #2;
    resetN[1] = 1'b0;
    #1;
    checkReset(1);
    cpuReq[1] = 1'b0;
    @(negedge clock);
    resetN[1] = 1'b1;
    repeat (8) @(negedge clock);
    applyStimulus(1, 0, 1'b0, 32'h50, 32'd0, 32'h0BADCAFE, 6);

    repeat (4) @(negedge clock);
    for (int q = 0; q < 4; q++)
      checkOutput($sformatf("pending queue %0d", q), 32'(expQ[q].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
